softmax_tile_sched: RTL
=======================

Name: softmax_tile_sched

Overview:
- Sequences one safe-softmax engine across a row split into TILES tiles of NUM words each, in online-softmax (flash-attention) style.
- Accepts tiles from upstream over a valid/ready handshake and holds each tile stable while the engine runs.
- Feeds back the engine's running max and exp-sum from tile to tile.
- Emits each tile's normalised words downstream, then the final row statistics.

Parameters:
- D_W, 8, data word width (8 or 16).
- NUM, 16, words per tile; must match the engine.
- TILES, 4, tiles per row; minimum 1.
- TIMEOUT, 255, maximum cycles the engine may run one tile before an error is flagged.

Ports:
- I_CLK  in  1  clock.
- I_RST_N  in  1  asynchronous active-low reset.
- I_ROW_START  in  1  single-cycle pulse that begins a row.
- I_TILE_VLD  in  1  upstream tile valid.
- O_TILE_RDY  out  1  tile accepted when I_TILE_VLD and O_TILE_RDY are both high.
- I_TILE_DATA  in  D_W x NUM  tile words.
- O_SM_START  out  1  engine start; held high for the whole computation.
- O_SM_DATA  out  D_W x NUM  latched tile, held stable while O_SM_START is high.
- O_SM_X_MAX  out  D_W  running max presented to the engine.
- O_SM_EXP_SUM  out  16  running exp-sum presented to the engine.
- I_SM_VLD  in  1  engine done, single-cycle pulse.
- I_SM_X_MAX  in  D_W  engine's updated max.
- I_SM_EXP_SUM  in  16  engine's updated exp-sum.
- I_SM_DATA  in  D_W x NUM  engine result; valid only in the I_SM_VLD cycle.
- O_OUT_VLD  out  1  result tile valid.
- I_OUT_RDY  in  1  downstream ready.
- O_OUT_DATA  out  D_W x NUM  captured result.
- O_OUT_IDX  out  clog2(TILES) (minimum 1)  tile index within the row.
- O_OUT_LAST  out  1  high with the final tile of the row.
- O_ROW_MAX  out  D_W  final row max.
- O_ROW_SUM  out  16  final row exp-sum.
- O_ROW_DONE  out  1  single-cycle pulse when the row completes.
- O_BUSY  out  1  high in every state except S_IDLE.
- O_ERR  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values: state S_IDLE; every output 0, all arrays zeroed; internal run_max = MIN_NEG ({1'b1, (D_W-1)'b0}); run_sum = 0; tile counter = 0; watchdog = 0.
- All outputs are registered.
- S_IDLE:
  - I_ROW_START → S_WAIT_TILE; run_max <= MIN_NEG, run_sum <= 0, tile_cnt <= 0.
  - I_ROW_START in any other state is ignored.
- S_WAIT_TILE:
  - O_TILE_RDY = 1 (combinational from state).
  - On handshake: O_SM_DATA <= I_TILE_DATA, O_SM_X_MAX <= run_max, O_SM_EXP_SUM <= run_sum, O_SM_START <= 1 → S_RUN.
- S_RUN:
  - O_TILE_RDY = 0; O_SM_DATA, O_SM_X_MAX and O_SM_EXP_SUM are frozen.
  - The watchdog increments every cycle.
  - On I_SM_VLD: O_SM_START <= 0 on that same edge, so the engine, which is in idle with its valid high, does not restart.
  - Also on I_SM_VLD: run_max <= I_SM_X_MAX, run_sum <= I_SM_EXP_SUM, O_OUT_DATA <= I_SM_DATA, O_OUT_IDX <= tile_cnt, O_OUT_LAST <= (tile_cnt == TILES-1), O_OUT_VLD <= 1, watchdog <= 0 → S_OUT.
  - Watchdog reaching TIMEOUT without I_SM_VLD: O_ERR <= 1, O_SM_START <= 0, O_OUT_VLD stays 0, row abandoned → S_IDLE.
- S_OUT:
  - O_OUT_VLD is held, and O_OUT_DATA, O_OUT_IDX and O_OUT_LAST are stable, until I_OUT_RDY.
  - On handshake, if not last: tile_cnt++ → S_WAIT_TILE.
  - On handshake, if last: O_ROW_MAX <= run_max, O_ROW_SUM <= run_sum, O_ROW_DONE <= 1 for one cycle → S_IDLE.
  - Back-pressure: the next tile is not accepted until the current output is consumed; at most one tile is in flight.
- TILES = 1: the first tile is also the last tile.
- Tile counter wrap: returns to 0 only via a new I_ROW_START.
- Simultaneous I_SM_VLD and watchdog expiry: I_SM_VLD wins and O_ERR is not set.
- Reset mid-operation: everything returns to reset values immediately; O_SM_START drops asynchronously.
- Minimum spacing between engine runs: O_SM_START is low for at least 2 cycles between tiles (S_OUT plus S_WAIT_TILE).

Test Plan:
- D_W=8, NUM=16, TILES=2 with a real engine; I_ROW_START, tile0 all 0x00 → O_SM_X_MAX=0x80 and O_SM_EXP_SUM=0x0000 during tile0; O_OUT_IDX=0, O_OUT_LAST=0.
- Continue the row with tile1 all 0x10 → O_SM_X_MAX equals the engine's tile0 I_SM_X_MAX (0x00) during tile1; O_OUT_LAST=1; O_ROW_DONE pulses once; O_ROW_MAX=0x10; O_BUSY drops the next cycle.
- Hold I_OUT_RDY=0 for 20 cycles after tile0's result → O_OUT_VLD and O_OUT_DATA stable throughout; O_TILE_RDY=0; no second O_SM_START.
- Engine model that never asserts I_SM_VLD, TIMEOUT=8 → O_ERR=1 nine cycles after O_SM_START rose; O_SM_START=0; state S_IDLE; O_ERR persists across a new row.
- I_ROW_START pulsed while in S_RUN → ignored; row statistics unchanged.
- Assert I_RST_N=0 during S_RUN → outputs zero; O_SM_START low; a new row afterwards starts from run_max=0x80.

Source files
------------

// File: rtl/softmax_tile_sched.sv
// Tile scheduler for an online (flash-style) safe-softmax engine: latches one tile at a time,
// carries the running max/exp-sum between tiles and streams results plus final row statistics.
module softmax_tile_sched #(
    parameter int D_W     = 8,
    parameter int NUM     = 16,
    parameter int TILES   = 4,
    parameter int TIMEOUT = 255,
    localparam int IDX_W  = (TILES > 1) ? $clog2(TILES) : 1
) (
    input  logic                     I_CLK,
    input  logic                     I_RST_N,
    input  logic                     I_ROW_START,
    input  logic                     I_TILE_VLD,
    output logic                     O_TILE_RDY,
    input  logic [NUM-1:0][D_W-1:0]  I_TILE_DATA,
    output logic                     O_SM_START,
    output logic [NUM-1:0][D_W-1:0]  O_SM_DATA,
    output logic [D_W-1:0]           O_SM_X_MAX,
    output logic [15:0]              O_SM_EXP_SUM,
    input  logic                     I_SM_VLD,
    input  logic [D_W-1:0]           I_SM_X_MAX,
    input  logic [15:0]              I_SM_EXP_SUM,
    input  logic [NUM-1:0][D_W-1:0]  I_SM_DATA,
    output logic                     O_OUT_VLD,
    input  logic                     I_OUT_RDY,
    output logic [NUM-1:0][D_W-1:0]  O_OUT_DATA,
    output logic [IDX_W-1:0]         O_OUT_IDX,
    output logic                     O_OUT_LAST,
    output logic [D_W-1:0]           O_ROW_MAX,
    output logic [15:0]              O_ROW_SUM,
    output logic                     O_ROW_DONE,
    output logic                     O_BUSY,
    output logic                     O_ERR
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [D_W-1:0]   MIN_NEG  = {1'b1, {(D_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TILE = 2'd1,
        S_RUN       = 2'd2,
        S_OUT       = 2'd3
    } state_t;

    state_t           state_r;
    logic [D_W-1:0]   run_max_r;
    logic [15:0]      run_sum_r;
    logic [IDX_W-1:0] tile_cnt_r;
    logic [WD_W-1:0]  wd_r;

    // Row sequencer: state, running statistics and every registered output.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_r      <= S_IDLE;
            run_max_r    <= MIN_NEG;
            run_sum_r    <= 16'h0000;
            tile_cnt_r   <= '0;
            wd_r         <= '0;
            O_TILE_RDY   <= 1'b0;
            O_SM_START   <= 1'b0;
            O_SM_DATA    <= '0;
            O_SM_X_MAX   <= '0;
            O_SM_EXP_SUM <= 16'h0000;
            O_OUT_VLD    <= 1'b0;
            O_OUT_DATA   <= '0;
            O_OUT_IDX    <= '0;
            O_OUT_LAST   <= 1'b0;
            O_ROW_MAX    <= '0;
            O_ROW_SUM    <= 16'h0000;
            O_ROW_DONE   <= 1'b0;
            O_BUSY       <= 1'b0;
            O_ERR        <= 1'b0;
        end else begin
            O_ROW_DONE <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (I_ROW_START) begin
                        run_max_r  <= MIN_NEG;
                        run_sum_r  <= 16'h0000;
                        tile_cnt_r <= '0;
                        O_TILE_RDY <= 1'b1;
                        O_BUSY     <= 1'b1;
                        state_r    <= S_WAIT_TILE;
                    end
                end
                S_WAIT_TILE: begin
                    if (I_TILE_VLD) begin
                        O_SM_DATA    <= I_TILE_DATA;
                        O_SM_X_MAX   <= run_max_r;
                        O_SM_EXP_SUM <= run_sum_r;
                        O_SM_START   <= 1'b1;
                        O_TILE_RDY   <= 1'b0;
                        wd_r         <= '0;
                        state_r      <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A done pulse on the expiry cycle still counts as success.
                    if (I_SM_VLD) begin
                        O_SM_START <= 1'b0;
                        run_max_r  <= I_SM_X_MAX;
                        run_sum_r  <= I_SM_EXP_SUM;
                        O_OUT_DATA <= I_SM_DATA;
                        O_OUT_IDX  <= tile_cnt_r;
                        O_OUT_LAST <= (tile_cnt_r == LAST_IDX);
                        O_OUT_VLD  <= 1'b1;
                        wd_r       <= '0;
                        state_r    <= S_OUT;
                    end else if (wd_r == WD_LIMIT) begin
                        O_ERR      <= 1'b1;
                        O_SM_START <= 1'b0;
                        O_BUSY     <= 1'b0;
                        wd_r       <= '0;
                        state_r    <= S_IDLE;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                S_OUT: begin
                    if (I_OUT_RDY) begin
                        O_OUT_VLD <= 1'b0;
                        if (O_OUT_LAST) begin
                            O_ROW_MAX  <= run_max_r;
                            O_ROW_SUM  <= run_sum_r;
                            O_ROW_DONE <= 1'b1;
                            O_BUSY     <= 1'b0;
                            state_r    <= S_IDLE;
                        end else begin
                            tile_cnt_r <= tile_cnt_r + IDX_W'(1);
                            O_TILE_RDY <= 1'b1;
                            state_r    <= S_WAIT_TILE;
                        end
                    end
                end
                default: begin
                    O_TILE_RDY <= 1'b0;
                    O_SM_START <= 1'b0;
                    O_OUT_VLD  <= 1'b0;
                    O_BUSY     <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
